rc4_decrypt: RTL and testbench

Keystream-generation and decryption stage directly downstream of `arcfour`. Once `arcfour` has initialised and key-scheduled the 256-byte S memory, this block runs the RC4 PRGA over S and XORs each keystream byte with one ciphertext byte from the encrypted-message ROM. Plaintext goes to the decrypted-message RAM. Each plaintext byte is checked for lowercase/space, which gives the key-search controller a pass/fail verdict on the key.

---
 rtl/rc4_decrypt.sv | 177 +++++++++++++++++
 tb/tb_rc4_decrypt.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_decrypt.sv
// RC4 PRGA over a pre-scheduled S memory: XORs keystream with the ciphertext ROM,
// writes plaintext to D and reports whether every byte was lowercase or space.
module rc4_decrypt #(
   parameter int MSG_LEN = 32,
   parameter int K_W     = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start_sig,
   output logic [7:0]     s_address,
   output logic [7:0]     s_ram_in,
   output logic           s_write_enable,
   input  logic [7:0]     s_ram_out,
   output logic [K_W-1:0] rom_address,
   input  logic [7:0]     rom_data,
   output logic [K_W-1:0] d_address,
   output logic [7:0]     d_data,
   output logic           d_write_enable,
   output logic           decrypt_finished,
   output logic           msg_valid
);

   typedef enum logic [3:0] {
      S_IDLE, S_RD_SI, S_LATCH_SI, S_RD_SJ, S_LATCH_SJ,
      S_WR_SI, S_WR_SJ, S_RD_F, S_LATCH_F, S_WR_D, S_DONE
   } state_t;

   localparam logic [K_W-1:0] LAST_K = K_W'(MSG_LEN - 1);

   state_t         state_q, state_d;
   logic [7:0]     i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d, f_q, f_d, e_q, e_d;
   logic [K_W-1:0] k_q, k_d;
   logic [7:0]     s_addr_q, s_addr_d, s_din_q, s_din_d;
   logic           s_we_q, s_we_d;
   logic [K_W-1:0] rom_addr_q, rom_addr_d, d_addr_q, d_addr_d;
   logic [7:0]     d_dat_q, d_dat_d;
   logic           d_we_q, d_we_d, fin_q, fin_d, valid_q, valid_d;

   function automatic logic is_text(input logic [7:0] b);
      return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
   endfunction

   // Outputs are registered: each state's bus values are computed on the edge entering it.
   always_comb begin
      state_d    = state_q;
      i_d        = i_q;
      j_d        = j_q;
      k_d        = k_q;
      si_d       = si_q;
      sj_d       = sj_q;
      f_d        = f_q;
      e_d        = e_q;
      s_addr_d   = s_addr_q;
      s_din_d    = s_din_q;
      s_we_d     = 1'b0;
      rom_addr_d = rom_addr_q;
      d_addr_d   = d_addr_q;
      d_dat_d    = d_dat_q;
      d_we_d     = 1'b0;
      valid_d    = valid_q;
      fin_d      = (state_q == S_DONE);
      case (state_q)
         S_IDLE: begin
            if (start_sig) begin
               i_d      = 8'd1;
               j_d      = 8'd0;
               k_d      = '0;
               valid_d  = 1'b1;
               s_addr_d = 8'd1;
               state_d  = S_RD_SI;
            end
         end
         S_RD_SI: state_d = S_LATCH_SI;
         S_LATCH_SI: begin
            si_d     = s_ram_out;
            j_d      = j_q + s_ram_out;
            s_addr_d = j_q + s_ram_out;
            state_d  = S_RD_SJ;
         end
         S_RD_SJ: state_d = S_LATCH_SJ;
         S_LATCH_SJ: begin
            sj_d     = s_ram_out;
            s_addr_d = i_q;
            s_din_d  = s_ram_out;
            s_we_d   = 1'b1;
            state_d  = S_WR_SI;
         end
         S_WR_SI: begin
            s_addr_d = j_q;
            s_din_d  = si_q;
            s_we_d   = 1'b1;
            state_d  = S_WR_SJ;
         end
         S_WR_SJ: begin
            s_addr_d   = si_q + sj_q;
            rom_addr_d = k_q;
            state_d    = S_RD_F;
         end
         S_RD_F: state_d = S_LATCH_F;
         S_LATCH_F: begin
            f_d      = s_ram_out;
            e_d      = rom_data;
            d_addr_d = k_q;
            d_dat_d  = s_ram_out ^ rom_data;
            d_we_d   = 1'b1;
            state_d  = S_WR_D;
         end
         S_WR_D: begin
            if (!is_text(f_q ^ e_q)) begin
               valid_d = 1'b0;
               state_d = S_DONE;
            end else if (k_q == LAST_K) begin
               state_d = S_DONE;
            end else begin
               k_d      = k_q + 1'b1;
               i_d      = i_q + 8'd1;
               s_addr_d = i_q + 8'd1;
               state_d  = S_RD_SI;
            end
         end
         // A held start must be released before another run can begin.
         S_DONE: if (!start_sig) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         i_q        <= '0;
         j_q        <= '0;
         k_q        <= '0;
         si_q       <= '0;
         sj_q       <= '0;
         f_q        <= '0;
         e_q        <= '0;
         s_addr_q   <= '0;
         s_din_q    <= '0;
         s_we_q     <= 1'b0;
         rom_addr_q <= '0;
         d_addr_q   <= '0;
         d_dat_q    <= '0;
         d_we_q     <= 1'b0;
         fin_q      <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         i_q        <= i_d;
         j_q        <= j_d;
         k_q        <= k_d;
         si_q       <= si_d;
         sj_q       <= sj_d;
         f_q        <= f_d;
         e_q        <= e_d;
         s_addr_q   <= s_addr_d;
         s_din_q    <= s_din_d;
         s_we_q     <= s_we_d;
         rom_addr_q <= rom_addr_d;
         d_addr_q   <= d_addr_d;
         d_dat_q    <= d_dat_d;
         d_we_q     <= d_we_d;
         fin_q      <= fin_d;
         valid_q    <= valid_d;
      end
   end

   assign s_address        = s_addr_q;
   assign s_ram_in         = s_din_q;
   assign s_write_enable   = s_we_q;
   assign rom_address      = rom_addr_q;
   assign d_address        = d_addr_q;
   assign d_data           = d_dat_q;
   assign d_write_enable   = d_we_q;
   assign decrypt_finished = fin_q;
   assign msg_valid        = valid_q;

endmodule

// File: tb/tb_rc4_decrypt.sv
// Directed bench for rc4_decrypt with behavioural S memory, ciphertext ROM and plaintext RAM.
module tb_rc4_decrypt;
   localparam int MSG_LEN = 4;
   localparam int K_W     = 2;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           start_sig = 1'b0;
   logic [7:0]     s_address, s_ram_in, s_ram_out, rom_data, d_data;
   logic           s_write_enable, d_write_enable, decrypt_finished, msg_valid;
   logic [K_W-1:0] rom_address, d_address;

   logic [7:0] smem   [256];
   logic [7:0] s_init [256];
   logic [7:0] rom    [MSG_LEN];
   logic [7:0] dmem   [MSG_LEN];
   logic       load_req = 1'b0;
   int         cyc = 0, dwr_cnt = 0, swr_cnt = 0;
   int         dwr_cyc  [256];
   logic [7:0] swr_addr [256];
   logic [7:0] swr_data [256];

   int checks = 0;
   int failures = 0;

   rc4_decrypt #(.MSG_LEN(MSG_LEN), .K_W(K_W)) dut (
      .clk(clk), .reset(reset), .start_sig(start_sig),
      .s_address(s_address), .s_ram_in(s_ram_in), .s_write_enable(s_write_enable),
      .s_ram_out(s_ram_out), .rom_address(rom_address), .rom_data(rom_data),
      .d_address(d_address), .d_data(d_data), .d_write_enable(d_write_enable),
      .decrypt_finished(decrypt_finished), .msg_valid(msg_valid)
   );

   always #5 clk = ~clk;

   // Synchronous memories: read data appears the cycle after the address.
   always @(posedge clk) begin
      s_ram_out <= smem[s_address];
      rom_data  <= rom[rom_address];
      if (load_req) begin
         for (int x = 0; x < 256; x++) smem[x] = s_init[x];
         for (int x = 0; x < MSG_LEN; x++) dmem[x] = 8'hEE;
      end else if (s_write_enable) begin
         smem[s_address] = s_ram_in;
         if (swr_cnt < 256) begin
            swr_addr[swr_cnt] = s_address;
            swr_data[swr_cnt] = s_ram_in;
         end
         swr_cnt++;
      end
      if (d_write_enable) begin
         dmem[d_address] = d_data;
         if (dwr_cnt < 256) dwr_cyc[dwr_cnt] = cyc;
         dwr_cnt++;
      end
      cyc++;
   end

   task automatic set_identity();
      for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
   endtask

   task automatic load_mem();
      @(negedge clk) load_req = 1'b1;
      @(negedge clk) load_req = 1'b0;
   endtask

   task automatic set_rom(input logic [7:0] b0, b1, b2, b3);
      rom[0] = b0; rom[1] = b1; rom[2] = b2; rom[3] = b3;
   endtask

   task automatic release_start();
      @(negedge clk) start_sig = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   // Raises start before edge 0 and reports the edge index where decrypt_finished is first seen.
   task automatic run_msg(output int fin_edge, output int base);
      @(negedge clk);
      base = cyc;
      start_sig = 1'b1;
      fin_edge = -1;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (decrypt_finished) begin
            fin_edge = n;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] outs;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      outs = {s_address, s_ram_in, s_write_enable, rom_address, d_address, d_data,
              d_write_enable, decrypt_finished, msg_valid};
      checks++;
      if (outs !== 32'h0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=0", outs);
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_abc_message();
      int fin, base, d0, s0;
      logic [7:0] exp_d [4];
      exp_d = '{8'h61, 8'h62, 8'h63, 8'h20};
      set_identity();
      set_rom(8'h63, 8'h67, 8'h64, 8'h2D);
      load_mem();
      d0 = dwr_cnt; s0 = swr_cnt;
      run_msg(fin, base);
      checks++;
      if (fin !== 37) begin failures++; $display("FAIL abc_finish_edge got=%0d exp=37", fin); end
      checks++;
      if (msg_valid !== 1'b1) begin failures++; $display("FAIL abc_msg_valid got=%b exp=1", msg_valid); end
      for (int b = 0; b < 4; b++) begin
         checks++;
         if (dmem[b] !== exp_d[b]) begin
            failures++; $display("FAIL abc_d%0d got=%h exp=%h", b, dmem[b], exp_d[b]);
         end
         checks++;
         if (dwr_cyc[d0+b] - base !== 9*b + 9) begin
            failures++; $display("FAIL abc_write_edge%0d got=%0d exp=%0d", b, dwr_cyc[d0+b] - base, 9*b + 9);
         end
      end
      checks++;
      if ({smem[2], smem[3], smem[5], smem[4], smem[9], smem[1], smem[13]} !==
          {8'h03, 8'h05, 8'h02, 8'h09, 8'h04, 8'h01, 8'h0D}) begin
         failures++;
         $display("FAIL abc_final_s got=%h %h %h %h %h %h %h exp=03 05 02 09 04 01 0d",
                  smem[2], smem[3], smem[5], smem[4], smem[9], smem[1], smem[13]);
      end
      checks++;
      if (swr_cnt - s0 !== 8) begin failures++; $display("FAIL abc_s_write_count got=%0d exp=8", swr_cnt - s0); end
      release_start();
   endtask

   task automatic test_abort();
      int fin, base, d0;
      set_identity();
      set_rom(8'h00, 8'h00, 8'h00, 8'h00);
      load_mem();
      d0 = dwr_cnt;
      run_msg(fin, base);
      checks++;
      if (fin !== 10) begin failures++; $display("FAIL abort_finish_edge got=%0d exp=10", fin); end
      checks++;
      if (msg_valid !== 1'b0) begin failures++; $display("FAIL abort_msg_valid got=%b exp=0", msg_valid); end
      checks++;
      if (dwr_cnt - d0 !== 1) begin failures++; $display("FAIL abort_d_writes got=%0d exp=1", dwr_cnt - d0); end
      checks++;
      if (dmem[0] !== 8'h02 || dmem[1] !== 8'hEE) begin
         failures++; $display("FAIL abort_d_contents got=%h %h exp=02 ee", dmem[0], dmem[1]);
      end
      release_start();
   endtask

   task automatic test_wrap();
      int fin, base;
      set_identity();
      s_init[1] = 8'hF0;
      s_init[8'hF0] = 8'h20;
      set_rom(8'h71, 8'h00, 8'h00, 8'h00);
      load_mem();
      run_msg(fin, base);
      checks++;
      if (dmem[0] !== 8'h61) begin failures++; $display("FAIL wrap_d0 got=%h exp=61", dmem[0]); end
      checks++;
      if (smem[1] !== 8'h20 || smem[8'hF0] !== 8'hF0) begin
         failures++; $display("FAIL wrap_swap got=%h %h exp=20 f0", smem[1], smem[8'hF0]);
      end
      checks++;
      if (dmem[1] !== 8'hF4 || fin !== 19 || msg_valid !== 1'b0) begin
         failures++; $display("FAIL wrap_byte1_abort got=%h/%0d/%b exp=f4/19/0", dmem[1], fin, msg_valid);
      end
      release_start();
   endtask

   task automatic test_i_eq_j();
      int fin, base, s0;
      set_identity();
      set_rom(8'h63, 8'h00, 8'h00, 8'h00);
      load_mem();
      s0 = swr_cnt;
      run_msg(fin, base);
      checks++;
      if ({swr_addr[s0], swr_data[s0], swr_addr[s0+1], swr_data[s0+1]} !== 32'h01010101) begin
         failures++;
         $display("FAIL ieqj_writes got=%h/%h %h/%h exp=01/01 01/01",
                  swr_addr[s0], swr_data[s0], swr_addr[s0+1], swr_data[s0+1]);
      end
      checks++;
      if (smem[1] !== 8'h01 || fin !== 19) begin
         failures++; $display("FAIL ieqj_s1_finish got=%h/%0d exp=01/19", smem[1], fin);
      end
      release_start();
   endtask

   task automatic test_hold_restart();
      int fin, base, d0, s0, bad;
      logic [7:0] exp_d [4];
      exp_d = '{8'h61, 8'h62, 8'h63, 8'h20};
      set_identity();
      set_rom(8'h63, 8'h67, 8'h64, 8'h2D);
      load_mem();
      run_msg(fin, base);
      d0 = dwr_cnt; s0 = swr_cnt; bad = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (decrypt_finished !== 1'b1) bad++;
      end
      checks++;
      if (bad !== 0 || dwr_cnt !== d0 || swr_cnt !== s0) begin
         failures++; $display("FAIL hold_no_restart got=%0d/%0d/%0d exp=0/0/0", bad, dwr_cnt - d0, swr_cnt - s0);
      end
      load_mem();
      @(negedge clk) start_sig = 1'b0;
      @(negedge clk);
      base = cyc;
      start_sig = 1'b1;
      @(negedge clk);
      checks++;
      if (decrypt_finished !== 1'b0 || s_address !== 8'h01) begin
         failures++; $display("FAIL restart_begin got=%b/%h exp=0/01", decrypt_finished, s_address);
      end
      fin = -1;
      for (int n = 1; n < 300; n++) begin
         @(negedge clk);
         if (decrypt_finished) begin fin = n; break; end
      end
      checks++;
      if (fin !== 37 || {dmem[0], dmem[1], dmem[2], dmem[3]} !== {exp_d[0], exp_d[1], exp_d[2], exp_d[3]}) begin
         failures++;
         $display("FAIL restart_run got=%0d %h%h%h%h exp=37 61626320", fin, dmem[0], dmem[1], dmem[2], dmem[3]);
      end
      release_start();
   endtask

   task automatic test_reset_mid_run();
      int fin, base;
      logic [31:0] outs;
      set_identity();
      set_rom(8'h63, 8'h67, 8'h64, 8'h2D);
      load_mem();
      @(negedge clk);
      start_sig = 1'b1;
      for (int n = 0; n <= 22; n++) @(negedge clk);
      checks++;
      if (s_write_enable !== 1'b1 || s_address !== 8'h03) begin
         failures++; $display("FAIL midrun_wr_si got=%b/%h exp=1/03", s_write_enable, s_address);
      end
      reset = 1'b0;
      start_sig = 1'b0;
      #1;
      outs = {s_address, s_ram_in, s_write_enable, rom_address, d_address, d_data,
              d_write_enable, decrypt_finished, msg_valid};
      checks++;
      if (outs !== 32'h0) begin failures++; $display("FAIL midrun_async_reset got=%h exp=0", outs); end
      @(negedge clk) reset = 1'b1;
      load_mem();
      run_msg(fin, base);
      checks++;
      if (fin !== 37 || msg_valid !== 1'b1 || {dmem[0], dmem[1], dmem[2], dmem[3]} !== 32'h61626320) begin
         failures++;
         $display("FAIL after_reset_run got=%0d/%b %h%h%h%h exp=37/1 61626320",
                  fin, msg_valid, dmem[0], dmem[1], dmem[2], dmem[3]);
      end
      release_start();
   endtask

   initial begin
      for (int x = 0; x < 256; x++) smem[x] = 8'h00;
      for (int x = 0; x < MSG_LEN; x++) begin rom[x] = 8'h00; dmem[x] = 8'hEE; end
      test_reset();
      test_abc_message();
      test_abort();
      test_wrap();
      test_i_eq_j();
      test_hold_restart();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
